// File: rtl/random_num_gen_if.sv
// Output bus of the pattern-index generator: one 4-bit pseudo-random value.
interface random_num_gen_if;
    logic [3:0] num;

    modport master (output num);
    modport slave  (input  num);
endinterface

// File: rtl/random_num_gen.sv
// Free-running 4-bit pseudo-random source: 16-bit Fibonacci LFSR
// (x^16+x^14+x^13+x^11+1, shifted right), low nibble presented as num.
module random_num_gen #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              RST,
    random_num_gen_if.master  bus
);
    localparam int unsigned LFSR_W = 16;
    localparam int unsigned NUM_W  = 4;

    // A zero seed would lock the LFSR, so substitute the smallest legal state.
    localparam logic [LFSR_W-1:0] LOAD_VAL = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] lfsr;
    logic              fb;

    assign fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Reset wins; an all-zero state (SEU, power-up) is escaped on the next edge.
    always_ff @(posedge clk) begin
        if (RST) begin
            lfsr <= LOAD_VAL;
        end else if (lfsr == '0) begin
            lfsr <= LFSR_W'(1);
        end else begin
            lfsr <= {fb, lfsr[LFSR_W-1:1]};
        end
    end

    assign bus.num = lfsr[NUM_W-1:0];
endmodule

// File: tb/tb_random_num_gen.sv
// Self-checking bench for random_num_gen: reference LFSR model plus directed
// checks of reset, sequence, mid-run reset, full period, lock-up and zero seed.
module tb_random_num_gen;
    logic clk;
    logic RST;

    random_num_gen_if bus_a ();
    random_num_gen_if bus_z ();

    random_num_gen #(.SEED(16'hACE1)) dut  (.clk(clk), .RST(RST), .bus(bus_a));
    random_num_gen #(.SEED(16'h0000)) dut0 (.clk(clk), .RST(RST), .bus(bus_z));

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          chk_en   = 1'b0;

    logic [15:0] m_a;
    logic [15:0] m_z;
    int unsigned hist [16];
    int unsigned first_ret;
    int unsigned zero_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One step of x^16+x^14+x^13+x^11+1 read as a right shift: the new MSB is
    // the parity of the tapped positions 0,2,3,5 of the current state.
    function automatic logic [15:0] next_state(input logic [15:0] s);
        int taps [4] = '{0, 2, 3, 5};
        logic p = 1'b0;
        if (s == 16'h0000) return 16'h0001;
        foreach (taps[i]) p ^= s[taps[i]];
        return {p, s[15:1]};
    endfunction

    always @(posedge clk) begin
        if (RST) begin
            m_a = 16'hACE1;
            m_z = 16'h0001;
        end else begin
            m_a = next_state(m_a);
            m_z = next_state(m_z);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("num_vs_model", 32'(bus_a.num), 32'(m_a[3:0]));
            check("num0_vs_model", 32'(bus_z.num), 32'(m_z[3:0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        RST = 1'b1;
        tick();
        tick();
        // Reset load, both instances
        check("reset_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
        check("reset_num", 32'(bus_a.num), 32'h1);
        check("zseed_lfsr", 32'(dut0.lfsr), 32'h00000001);
        check("zseed_num", 32'(bus_z.num), 32'h1);
        chk_en = 1'b1;

        RST = 1'b0;
        tick();
        check("seq1_lfsr", 32'(dut.lfsr), 32'h00005670);
        check("seq1_num", 32'(bus_a.num), 32'h0);
        check("zseed_step_lfsr", 32'(dut0.lfsr), 32'h00008000);
        check("zseed_step_num", 32'(bus_z.num), 32'h0);
        tick();
        check("seq2_lfsr", 32'(dut.lfsr), 32'h0000AB38);
        check("seq2_num", 32'(bus_a.num), 32'h8);
        tick();
        check("seq3_lfsr", 32'(dut.lfsr), 32'h0000559C);
        check("seq3_num", 32'(bus_a.num), 32'hC);

        // Mid-run reset after 1000 cycles
        for (int i = 0; i < 997; i++) tick();
        RST = 1'b1;
        tick();
        check("midrst_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
        check("midrst_num", 32'(bus_a.num), 32'h1);
        RST = 1'b0;
        tick();
        check("midrst_next_lfsr", 32'(dut.lfsr), 32'h00005670);

        // Full period and nibble histogram
        RST = 1'b1;
        tick();
        RST = 1'b0;
        foreach (hist[v]) hist[v] = 0;
        first_ret = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            hist[bus_a.num]++;
            if (first_ret == 0 && dut.lfsr == 16'hACE1) first_ret = i;
        end
        check("period_first_return", 32'(first_ret), 32'd65535);
        check("hist_0", 32'(hist[0]), 32'd4095);
        for (int v = 1; v < 16; v++) check($sformatf("hist_%0d", v), 32'(hist[v]), 32'd4096);

        // Lock-up recovery: drive the register to zero between edges
        chk_en = 1'b0;
        force dut.lfsr = 16'h0000;
        #1;
        release dut.lfsr;
        m_a = 16'h0000;
        #1;
        check("lockup_zero_num", 32'(bus_a.num), 32'h0);
        tick();
        check("lockup_recover_lfsr", 32'(dut.lfsr), 32'h00000001);
        check("lockup_recover_num", 32'(bus_a.num), 32'h1);
        chk_en = 1'b1;
        zero_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (dut.lfsr == 16'h0000) zero_cnt++;
        end
        check("lockup_no_zero", 32'(zero_cnt), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
